// File: rtl/seg7_scan4.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Latches a 16-bit hex value and scans one digit per CLK_DIV-cycle slot; all pins are registered.
module seg7_scan4 #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic        frame
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;
  logic          tick;
  logic [3:0]    nibble;
  logic [3:0]    digit_on;

  // Active-low segment pattern, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_on[gi] = (idx_q == 2'(gi)) && !blank[gi];
  end

  always_comb begin
    tick     = (presc_q == LAST);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = load ? data_in : shadow_q;
    // wrap_q marks the edge where idx went 3->0; frame follows one cycle later
    // so it lines up with the registered outputs first showing digit 0.
    wrap_d   = tick && (idx_q == 2'd3);
    frame_d  = wrap_q;
    nibble   = 4'(shadow_q >> {idx_q, 2'b00});
    an_d     = ~digit_on;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    if (!blank[idx_q]) begin
      seg_d = decode(nibble);
      dp_d  = ~dp_in[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      wrap_q   <= 1'b0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      wrap_q   <= wrap_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign {AN3, AN2, AN1, AN0}          = an_q;
  assign {CA, CB, CC, CD, CE, CF, CG}  = seg_q;
  assign DP    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Bench for seg7_scan4: a CLK_DIV=4 and a CLK_DIV=1 instance share stimulus and are checked
// every cycle against an arithmetic display model, plus a vector table and corner sequences.
module tb_seg7_scan4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, frame_a, frame_b;

  seg7_scan4 #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in), .blank(blank),
    .AN0(an_a[0]), .AN1(an_a[1]), .AN2(an_a[2]), .AN3(an_a[3]),
    .CA(seg_a[6]), .CB(seg_a[5]), .CC(seg_a[4]), .CD(seg_a[3]),
    .CE(seg_a[2]), .CF(seg_a[1]), .CG(seg_a[0]),
    .DP(dp_a), .frame(frame_a)
  );

  seg7_scan4 #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in), .blank(blank),
    .AN0(an_b[0]), .AN1(an_b[1]), .AN2(an_b[2]), .AN3(an_b[3]),
    .CA(seg_b[6]), .CB(seg_b[5]), .CC(seg_b[4]), .CD(seg_b[3]),
    .CE(seg_b[2]), .CF(seg_b[1]), .CG(seg_b[0]),
    .DP(dp_b), .frame(frame_b)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;                      // clock edges since reset release
  logic [15:0] m_shadow = 16'h0;  // model of the latched value

  string seg_lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  typedef struct {
    logic        ld;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blk;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        frm;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [6:0] lit_bits(input logic [3:0] v);
    logic [6:0] r;
    string s;
    int k;
    r = 7'h7F;
    s = seg_lit[v];
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      r[6-k] = 1'b0;
    end
    return r;
  endfunction

  // Expected {AN3..AN0, CA..CG, DP, frame} after the coming edge.
  function automatic logic [12:0] model(input int div);
    int d;
    logic [3:0] nib;
    logic [12:0] r;
    d = (n / div) % 4;
    nib = 4'(m_shadow >> (4 * d));
    if (blank[d]) r = {4'hF, 7'h7F, 1'b1, 1'b0};
    else          r = {~(4'b0001 << d), lit_bits(nib), ~dp_in[d], 1'b0};
    r[0] = (n > 0) && (n % (4 * div) == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, n, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, n, got, exp);
    end
  endtask

  task automatic step();
    logic [12:0] ea, eb;
    ea = model(4);
    eb = model(1);
    if (load) m_shadow = data_in;
    @(posedge clk);
    #1;
    n++;
    check("dut_div4", {an_a, seg_a, dp_a, frame_a}, ea);
    check("dut_div1", {an_b, seg_b, dp_b, frame_b}, eb);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async_div4", {an_a, seg_a, dp_a, frame_a}, {4'hF, 7'h7F, 1'b1, 1'b0});
    check("rst_async_div1", {an_b, seg_b, dp_b, frame_b}, {4'hF, 7'h7F, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    m_shadow = 16'h0;
  endtask

  initial begin
    int fcnt, last, dark, d, cnt0, fb;
    logic [3:0] nib;

    tbl[0]  = '{1'b1, 16'h1234, 4'h0, 4'h0, 4'b1110, 7'b0000001, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 4'h0, 4'h0, 4'b1110, 7'b1001100, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 4'h0, 4'h0, 4'b1110, 7'b1001100, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 4'h0, 4'h0, 4'b1110, 7'b1001100, 1'b1, 1'b0};
    for (int i = 4; i < 8; i++)   tbl[i] = '{1'b0, 16'h0, 4'h0, 4'h0, 4'b1101, 7'b0000110, 1'b1, 1'b0};
    for (int i = 8; i < 12; i++)  tbl[i] = '{1'b0, 16'h0, 4'h0, 4'h0, 4'b1011, 7'b0010010, 1'b1, 1'b0};
    for (int i = 12; i < 16; i++) tbl[i] = '{1'b0, 16'h0, 4'h0, 4'h0, 4'b0111, 7'b1001111, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 16'h0000, 4'h0, 4'h0, 4'b1110, 7'b1001100, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 16'h0000, 4'h1, 4'h0, 4'b1110, 7'b1001100, 1'b0, 1'b0};

    #1;
    do_reset();

    // Reset release, load 0x1234 and one full frame of scanning.
    for (int i = 0; i < 18; i++) begin
      load = tbl[i].ld; data_in = tbl[i].data; dp_in = tbl[i].dp; blank = tbl[i].blk;
      step();
      check("table", {an_a, seg_a, dp_a, frame_a}, {tbl[i].an, tbl[i].seg, tbl[i].dpo, tbl[i].frm});
    end
    load = 1'b0; dp_in = 4'h0;

    // Free run: frame every 16 cycles, aligned with AN0.
    fcnt = 0; last = -1;
    for (int i = 0; i < 48; i++) begin
      step();
      if (frame_a) begin
        fcnt++;
        check_int("frame_an0", int'(an_a), 4'b1110);
        if (last >= 0) check_int("frame_spacing", n - last, 16);
        last = n;
      end
    end
    check_int("frame_count", fcnt, 3);

    // Blanked digit 1 with all-F value.
    load = 1'b1; data_in = 16'hFFFF; blank = 4'b0010;
    step();
    load = 1'b0;
    dark = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an_a == 4'hF) begin
        dark++;
        check_int("blank_seg", int'(seg_a), 7'h7F);
      end else begin
        check_int("f_seg", int'(seg_a), 7'b0111000);
      end
    end
    check_int("blank_cycles", dark, 4);

    // Decimal point on digit 3 only.
    blank = 4'h0; dp_in = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      step();
      check_int("dp_slot", int'(dp_a), (an_a == 4'b0111) ? 0 : 1);
    end

    // Load coincident with the tick edge.
    dp_in = 4'h0;
    for (int k = 0; k < 4 && (n % 4 != 3); k++) step();
    load = 1'b1; data_in = 16'hABCD;
    d = ((n + 1) / 4) % 4;
    step();
    load = 1'b0;
    step();
    nib = 4'(16'hABCD >> (4 * d));
    check_int("load_at_tick", int'(seg_a), int'(lit_bits(nib)));

    // Asynchronous reset in the middle of the AN2 slot.
    for (int k = 0; k < 20 && !(an_a == 4'b1011 && n % 4 == 2); k++) step();
    check_int("pre_rst_an2", int'(an_a), 4'b1011);
    do_reset();
    cnt0 = 0; fb = 0;
    for (int k = 0; k < 13; k++) begin
      step();
      if (k < 5 && an_a == 4'b1110) cnt0++;
      if (frame_b) fb++;
    end
    check_int("slot0_len_after_rst", cnt0, 4);
    check_int("div1_frames", fb, 3);

    // Randomized run against the model, with one reset in the middle.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      load    = ($urandom_range(0, 3) == 0);
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      blank   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
